div32by16_seq: RTL



---
 rtl/div32by16_seq_if.sv | 37 +++
 rtl/div32by16_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div32by16_seq_if.sv
// div32by16_seq_if
//   Operand/result handshake bundle for the sequential 32/16 signed divider.
//   master : the side that supplies operands and consumes results.
//   slave  : the divider itself.
//   Signals:
//     in_valid / in_ready          operand handshake
//     dividend [DW-1:0]            signed dividend
//     divisor  [VW-1:0]            signed divisor
//     out_valid / out_ready        result handshake
//     quotient [DW-1:0]            signed quotient, truncated toward zero
//     remainder[VW-1:0]            signed remainder, sign follows dividend
//     div_by_zero, overflow        result status flags
interface div32by16_seq_if #(
  parameter int DW = 32,
  parameter int VW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div32by16_seq.sv
// div32by16_seq
//   Sequential signed divider: 32-bit dividend / 16-bit divisor, producing a
//   quotient truncated toward zero and a remainder whose sign follows the
//   dividend. Operands are converted to magnitudes, divided with a bit-serial
//   restoring algorithm (MSB first), and the signs are re-applied at the end.
//   Divide-by-zero saturates the quotient toward the dividend's sign and
//   returns the low dividend bits as remainder; -2^31 / -1 saturates to
//   SAT_POS with overflow set.
//
//   Optional build macro DIV_RADIX4_EN: retire two quotient bits per cycle
//   (two cascaded trial subtractions), halving the iteration count. Results
//   are identical to the one-bit-per-cycle build.
//
//   Ports:
//     nvdla_core_clk  clock, rising edge
//     nvdla_core_rst  asynchronous active-high reset
//     bus             div32by16_seq_if.slave (operand and result handshakes)
module div32by16_seq #(
  parameter int            DW      = 32,
  parameter int            VW      = 16,
  parameter logic [DW-1:0] SAT_POS = 32'h7FFFFFFF,
  parameter logic [DW-1:0] SAT_NEG = 32'h80000000
) (
  input logic              nvdla_core_clk,
  input logic              nvdla_core_rst,
  div32by16_seq_if.slave   bus
);

`ifdef DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif

  localparam int            CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW / STEPS);
  localparam logic [DW-1:0] DVD_MIN  = {1'b1, {(DW-1){1'b0}}};

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] NORM = 3'd1;
  localparam logic [2:0] CALC = 3'd2;
  localparam logic [2:0] SIGN = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [DW-1:0] dividend_reg;
  logic [VW-1:0] divisor_reg;
  logic [DW-1:0] q_reg;          // dividend magnitude shifting out, quotient bits shifting in
  logic [VW-1:0] rem_reg;        // partial remainder, always < |divisor|
  logic [VW-1:0] dmag_reg;       // |divisor|; 0x8000 is the magnitude of -32768
  logic          sq_reg, sr_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] quotient_reg;
  logic [VW-1:0] remainder_reg;
  logic          dbz_reg, ovf_reg;

  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;

  // Unary minus of the most negative value wraps to itself, which read as
  // unsigned is exactly the required magnitude.
  assign dvd_mag = dividend_reg[DW-1] ? -dividend_reg : dividend_reg;
  assign dvs_mag = divisor_reg[VW-1]  ? -divisor_reg  : divisor_reg;

  // Restoring-division stages, chained combinationally; one stage per
  // quotient bit retired in a CALC cycle.
  logic [VW-1:0] rem_chain [0:STEPS];
  logic [DW-1:0] q_chain   [0:STEPS];

  assign rem_chain[0] = rem_reg;
  assign q_chain[0]   = q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_step
      logic [VW:0] shifted;
      logic        ge;
      // Bring the next dividend bit into the partial remainder, then keep
      // the trial difference only when it does not go negative.
      assign shifted          = {rem_chain[gi], q_chain[gi][DW-1]};
      assign ge               = (shifted >= {1'b0, dmag_reg});
      assign rem_chain[gi+1]  = ge ? VW'(shifted - {1'b0, dmag_reg}) : shifted[VW-1:0];
      assign q_chain[gi+1]    = {q_chain[gi][DW-2:0], ge};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = NORM;
      NORM:    state_next = (divisor_reg == '0) ? SIGN : CALC;
      CALC:    if (cnt_reg == CW'(1)) state_next = SIGN;
      SIGN:    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_reg     <= IDLE;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      dmag_reg      <= '0;
      sq_reg        <= 1'b0;
      sr_reg        <= 1'b0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            dividend_reg <= bus.dividend;
            divisor_reg  <= bus.divisor;
          end
        end
        NORM: begin
          q_reg    <= dvd_mag;
          dmag_reg <= dvs_mag;
          rem_reg  <= '0;
          sq_reg   <= dividend_reg[DW-1] ^ divisor_reg[VW-1];
          sr_reg   <= dividend_reg[DW-1];
          cnt_reg  <= CNT_LOAD;
        end
        CALC: begin
          q_reg   <= q_chain[STEPS];
          rem_reg <= rem_chain[STEPS];
          cnt_reg <= cnt_reg - CW'(1);
        end
        SIGN: begin
          if (divisor_reg == '0) begin
            quotient_reg  <= dividend_reg[DW-1] ? SAT_NEG : SAT_POS;
            remainder_reg <= dividend_reg[VW-1:0];
            dbz_reg       <= 1'b1;
            ovf_reg       <= 1'b0;
          end else if ((dividend_reg == DVD_MIN) && (divisor_reg == '1)) begin
            // +2^31 is not representable; the magnitude path would wrap.
            quotient_reg  <= SAT_POS;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b1;
          end else begin
            quotient_reg  <= sq_reg ? -q_reg : q_reg;
            remainder_reg <= sr_reg ? -rem_reg : rem_reg;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

endmodule
